// File: rtl/ifm_rd_master_if.sv
// IFM read bus: AXI read address/data channels plus the outbound
// feature-map stream toward the compute core.
interface ifm_rd_master_if #(
    parameter int DATA_W = 64
);
    logic [31:0]       m_axi_ifm_araddr;
    logic              m_axi_ifm_arvalid;
    logic              m_axi_ifm_arready;
    logic [DATA_W-1:0] m_axi_ifm_rdata;
    logic              m_axi_ifm_rvalid;
    logic              m_axi_ifm_rready;
    logic [DATA_W-1:0] ifm_data;
    logic              ifm_valid;
    logic              ifm_ready;

    modport master (
        output m_axi_ifm_araddr,
        output m_axi_ifm_arvalid,
        input  m_axi_ifm_arready,
        input  m_axi_ifm_rdata,
        input  m_axi_ifm_rvalid,
        output m_axi_ifm_rready,
        output ifm_data,
        output ifm_valid,
        input  ifm_ready
    );

    modport slave (
        input  m_axi_ifm_araddr,
        input  m_axi_ifm_arvalid,
        output m_axi_ifm_arready,
        output m_axi_ifm_rdata,
        output m_axi_ifm_rvalid,
        input  m_axi_ifm_rready,
        input  ifm_data,
        input  ifm_valid,
        output ifm_ready
    );
endinterface

// File: rtl/ifm_rd_master.sv
// Input feature-map read master: single-beat AXI reads into a
// show-ahead FIFO that feeds the compute-core stream.
module ifm_rd_master #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] num_words,
    output logic        busy,
    output logic        done,
    ifm_rd_master_if.master bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] STEP = 32'(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [16:0]       total_q, req_q, dlv_q, in_flight;
    logic [31:0]       next_q, araddr_q;
    logic              arvalid_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;
    logic              ar_fire, raise, wr, rd, last, launch;

    assign launch    = (state_q == S_IDLE) && start;
    assign ar_fire   = arvalid_q && bus.m_axi_ifm_arready;
    assign in_flight = req_q - dlv_q;
    // a raised-but-unaccepted AR already holds its FIFO slot
    assign raise = (state_q == S_RUN) && (!arvalid_q || ar_fire) &&
                   (req_q < total_q) && (in_flight < 17'(DEPTH));
    assign wr    = bus.m_axi_ifm_rvalid && (state_q == S_RUN);
    assign rd    = (cnt_q != '0) && bus.ifm_ready;
    assign last  = rd && (dlv_q == total_q - 17'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start)
                state_d = (num_words == 16'd0) ? S_DONE : S_RUN;
            S_RUN:  if (last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy                 = (state_q != S_IDLE);
        done                 = (state_q == S_DONE);
        bus.m_axi_ifm_rready = (state_q == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q   <= '0;
            req_q     <= '0;
            dlv_q     <= '0;
            next_q    <= '0;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            if (launch) begin
                total_q <= {1'b0, num_words};
                req_q   <= '0;
                dlv_q   <= '0;
                next_q  <= base_addr;
            end else begin
                if (raise) begin
                    req_q  <= req_q + 17'd1;
                    next_q <= next_q + STEP;
                end
                if (rd) dlv_q <= dlv_q + 17'd1;
            end
            if (raise) begin
                arvalid_q <= 1'b1;
                araddr_q  <= next_q;
            end else if (ar_fire) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + AW'(1);
            if (rd) rptr_q <= rptr_q + AW'(1);
            unique case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q] <= bus.m_axi_ifm_rdata;
    end

    assign bus.m_axi_ifm_araddr  = araddr_q;
    assign bus.m_axi_ifm_arvalid = arvalid_q;
    assign bus.ifm_valid         = (cnt_q != '0);
    assign bus.ifm_data          = (cnt_q != '0) ? mem[rptr_q] : '0;
endmodule

// File: tb/tb_ifm_rd_master.sv
// Bench for ifm_rd_master: random AXI slave and stream sink with
// address/data expectations computed from the transfer parameters.
module tb_ifm_rd_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        busy, done;

    always #5 clk = ~clk;

    ifm_rd_master_if #(.DATA_W(64)) bus ();

    ifm_rd_master #(.DATA_W(64), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int ar_mode, r_mode, s_mode;
    int done_cnt, arv_seen, hold_err;
    logic [31:0] ar_log [$];
    logic [31:0] pend_q [$];
    logic [63:0] out_log [$];
    logic        prev_pend;
    logic [31:0] prev_addr;

    function automatic logic [63:0] beat(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    // slave + sink: inputs set at negedge, handshakes logged for next posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            prev_pend = 1'b0;
            bus.m_axi_ifm_arready = 1'b0;
            bus.m_axi_ifm_rvalid  = 1'b0;
            bus.m_axi_ifm_rdata   = '0;
            bus.ifm_ready         = 1'b0;
        end else begin
            if (prev_pend && (bus.m_axi_ifm_arvalid !== 1'b1 ||
                              bus.m_axi_ifm_araddr !== prev_addr))
                hold_err++;
            bus.m_axi_ifm_arready = (ar_mode == 0) ? 1'b1 :
                                    1'($urandom_range(0, 1));
            if (pend_q.size() > 0 &&
                (r_mode == 0 || $urandom_range(0, 1) == 1)) begin
                bus.m_axi_ifm_rvalid = 1'b1;
                bus.m_axi_ifm_rdata  = beat(pend_q[0]);
            end else begin
                bus.m_axi_ifm_rvalid = 1'b0;
                bus.m_axi_ifm_rdata  = {$urandom, $urandom};
            end
            bus.ifm_ready = (s_mode == 0) ? 1'b1 :
                            (s_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.m_axi_ifm_arvalid) arv_seen++;
            if (done) done_cnt++;
            if (bus.m_axi_ifm_arvalid && bus.m_axi_ifm_arready) begin
                ar_log.push_back(bus.m_axi_ifm_araddr);
                pend_q.push_back(bus.m_axi_ifm_araddr);
            end
            if (bus.m_axi_ifm_rvalid && bus.m_axi_ifm_rready)
                void'(pend_q.pop_front());
            if (bus.ifm_valid && bus.ifm_ready)
                out_log.push_back(bus.ifm_data);
            prev_pend = bus.m_axi_ifm_arvalid && !bus.m_axi_ifm_arready;
            prev_addr = bus.m_axi_ifm_araddr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] b, input logic [15:0] n);
        ar_log.delete();
        out_log.delete();
        done_cnt = 0;
        arv_seen = 0;
        hold_err = 0;
        base_addr = b;
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        base_addr = $urandom;
        num_words = 16'($urandom);
    endtask

    task automatic wait_done(input int budget, input int poke, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            start = (i == poke);
            if (i == poke) begin
                base_addr = $urandom;
                num_words = 16'($urandom_range(1, 40));
            end
            tick();
            start = 1'b0;
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        ar_mode = 0; r_mode = 0; s_mode = 0;
        repeat (3) tick();
        total++;
        if ({bus.m_axi_ifm_arvalid, bus.m_axi_ifm_rready, bus.ifm_valid,
             busy, done} !== 5'b0)
            begin bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                {bus.m_axi_ifm_arvalid, bus.m_axi_ifm_rready,
                 bus.ifm_valid, busy, done}); end
        total++;
        if (bus.m_axi_ifm_araddr !== 32'h0)
            begin bad++; $display("FAIL reset_araddr got=%h exp=0",
                bus.m_axi_ifm_araddr); end
        total++;
        if (bus.ifm_data !== 64'h0)
            begin bad++; $display("FAIL reset_data got=%h exp=0",
                bus.ifm_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        int e;
        ar_mode = 0; r_mode = 0; s_mode = 0;
        launch(32'h1000, 16'd4);
        wait_done(200, -1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
        total++;
        if (busy !== 1'b1)
            begin bad++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
        tick();
        total++;
        if ({busy, done} !== 2'b00)
            begin bad++; $display("FAIL basic_busy_fall got=%b exp=00",
                {busy, done}); end
        e = (ar_log.size() == 4) ? 0 : 1;
        foreach (ar_log[k])
            if (ar_log[k] !== 32'h1000 + 32'(k * 8)) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL basic_addr got=%p exp=1000..1018",
            ar_log); end
        e = (out_log.size() == 4) ? 0 : 1;
        foreach (out_log[k])
            if (out_log[k] !== beat(32'h1000 + 32'(k * 8))) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL basic_data got=%0d errs exp=0", e); end
        total++;
        if (done_cnt !== 1)
            begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_zero();
        launch(32'h2000, 16'd0);
        total++;
        if ({busy, done} !== 2'b11)
            begin bad++; $display("FAIL zero_done got=%b exp=11", {busy, done}); end
        tick();
        total++;
        if ({busy, done} !== 2'b00)
            begin bad++; $display("FAIL zero_idle got=%b exp=00", {busy, done}); end
        total++;
        if (arv_seen !== 0 || done_cnt !== 1)
            begin bad++; $display("FAIL zero_ar got=%0d/%0d exp=0/1",
                arv_seen, done_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        logic [31:0] b;
        ar_mode = 0; r_mode = 0; s_mode = 2;
        b = $urandom & ~32'h7;
        launch(b, 16'd20);
        repeat (40) tick();
        total++;
        if (ar_log.size() !== 8 || bus.m_axi_ifm_arvalid !== 1'b0)
            begin bad++; $display("FAIL bp_cap got=%0d/%b exp=8/0",
                ar_log.size(), bus.m_axi_ifm_arvalid); end
        s_mode = 0;
        wait_done(400, -1, ok);
        tick();
        total++;
        if (!ok) begin bad++; $display("FAIL bp_timeout got=0 exp=1"); end
        e = (ar_log.size() == 20 && out_log.size() == 20) ? 0 : 1;
        foreach (ar_log[k]) if (ar_log[k] !== b + 32'(k * 8)) e++;
        foreach (out_log[k]) if (out_log[k] !== beat(b + 32'(k * 8))) e++;
        total++;
        if (e != 0) begin bad++; $display("FAIL bp_stream got=%0d errs exp=0", e); end
    endtask

    task automatic test_random();
        bit ok;
        int e;
        int n;
        logic [31:0] b;
        for (int it = 0; it < 6; it++) begin
            ar_mode = 1; r_mode = 1; s_mode = 1;
            b = $urandom & ~32'h7;
            n = $urandom_range(1, 30);
            launch(b, 16'(n));
            wait_done(3000, 3, ok);
            tick();
            total++;
            if (!ok) begin bad++; $display("FAIL rnd_timeout it=%0d got=0 exp=1", it); end
            total++;
            if (hold_err !== 0)
                begin bad++; $display("FAIL rnd_hold it=%0d got=%0d exp=0",
                    it, hold_err); end
            e = (ar_log.size() == n && out_log.size() == n) ? 0 : 1;
            foreach (ar_log[k]) if (ar_log[k] !== b + 32'(k * 8)) e++;
            foreach (out_log[k]) if (out_log[k] !== beat(b + 32'(k * 8))) e++;
            total++;
            if (e != 0) begin bad++; $display("FAIL rnd_stream it=%0d got=%0d errs exp=0",
                it, e); end
            total++;
            if (done_cnt !== 1)
                begin bad++; $display("FAIL rnd_done it=%0d got=%0d exp=1",
                    it, done_cnt); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ar_mode = 0; r_mode = 0; s_mode = 0;
        launch(32'hFFFF_FFF8, 16'd2);
        wait_done(100, -1, ok);
        tick();
        total++;
        if (!ok || ar_log.size() != 2 || ar_log[0] !== 32'hFFFF_FFF8 ||
            ar_log[1] !== 32'h0)
            begin bad++; $display("FAIL wrap_addr got=%p exp=fffffff8,0", ar_log); end
        total++;
        if (out_log.size() != 2 || out_log[1] !== beat(32'h0))
            begin bad++; $display("FAIL wrap_data got=%p", out_log); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int i;
        ar_mode = 0; r_mode = 0; s_mode = 0;
        launch(32'h4000, 16'd10);
        i = 0;
        while (out_log.size() < 3 && i < 200) begin tick(); i++; end
        total++;
        if (out_log.size() < 3)
            begin bad++; $display("FAIL rmid_progress got=%0d exp=3", out_log.size()); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.m_axi_ifm_arvalid, bus.m_axi_ifm_rready, bus.ifm_valid,
             busy, done} !== 5'b0 || bus.m_axi_ifm_araddr !== 32'h0 ||
            bus.ifm_data !== 64'h0)
            begin bad++; $display("FAIL rmid_outputs got=%b/%h exp=0",
                {bus.m_axi_ifm_arvalid, bus.m_axi_ifm_rready, bus.ifm_valid,
                 busy, done}, bus.m_axi_ifm_araddr); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        total++;
        if (done_cnt !== 0 || busy !== 1'b0)
            begin bad++; $display("FAIL rmid_nodone got=%0d/%b exp=0/0",
                done_cnt, busy); end
        launch(32'h5000, 16'd2);
        wait_done(100, -1, ok);
        tick();
        total++;
        if (!ok || ar_log.size() != 2 || ar_log[1] !== 32'h5008 ||
            out_log.size() != 2 || out_log[0] !== beat(32'h5000) ||
            out_log[1] !== beat(32'h5008) || done_cnt !== 1)
            begin bad++; $display("FAIL rmid_restart got=%0d/%0d/%0d exp=2/2/1",
                ar_log.size(), out_log.size(), done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
